// File: rtl/metric_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : metric_memory_pkg
// Purpose  : Shared parameters for the Viterbi path-metric memory and the
//            ACS unit that feeds it, plus the init-sweep state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package metric_memory_pkg;

    // Segment address width; the trellis holds 2^(WD_FSM+2) states.
    localparam int WD_FSM   = 6;
    // Two's-complement path-metric width.
    localparam int WD_METR  = 8;
    // Width of a full state index.
    localparam int WD_STATE = WD_FSM + 2;
    // Number of ACS lanes working in parallel.
    localparam int N_ACS    = 4;
    // Starting metric of every state except state 0.
    localparam logic [WD_METR-1:0] INIT_HIGH = 8'h40;

    // ACS unit constants: a radix-2 butterfly reads two old metrics per lane.
    localparam int ACS_RADIX        = 2;
    localparam int METRICS_PER_WORD = ACS_RADIX * N_ACS;

    // Initialisation sweep controller states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } init_state_t;

endpackage
`default_nettype wire

// File: rtl/metric_bank.sv
`default_nettype none
// ============================================================================
// Module   : metric_bank
// Purpose  : One bank of path metrics. Combinational word read, synchronous
//            write of the low half, the high half, or both halves of a word.
// Ports    : Clock2  - write clock (rising edge)
//            rd_addr - word index for the combinational read
//            rd_data - word at rd_addr
//            wr_lo   - write low half-word of wr_addr
//            wr_hi   - write high half-word of wr_addr
//            wr_addr - word index for the write
//            wr_data - full-word write data (each half taken when enabled)
// Revision : 1.0 - initial release
// ============================================================================
module metric_bank
    import metric_memory_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int HALF_W = 32
) (
    input  logic                Clock2,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [2*HALF_W-1:0] rd_data,
    input  logic                wr_lo,
    input  logic                wr_hi,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [2*HALF_W-1:0] wr_data
);

    // No reset on the array: contents survive Reset and are only defined
    // after an initialisation sweep.
    logic [2*HALF_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clock2) begin
        if (wr_lo) begin
            mem[wr_addr][HALF_W-1:0] <= wr_data[HALF_W-1:0];
        end
        if (wr_hi) begin
            mem[wr_addr][2*HALF_W-1:HALF_W] <= wr_data[2*HALF_W-1:HALF_W];
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/metric_memory.sv
`default_nettype none
// ============================================================================
// Module   : metric_memory
// Purpose  : Double-buffered path-metric store for a Viterbi decoder. The ACS
//            unit reads old metrics from one bank while writing new metrics
//            into the other; an init sweep loads starting metrics into both.
// Ports    : Clock2         - clock, rising edge
//            Reset          - asynchronous active-low reset (FSM only)
//            Active         - enable ACS write-back
//            Init           - one-cycle pulse starting the init sweep
//            MMBlockSelect  - read bank; writes go to the other bank
//            MMReadAddress  - read word index
//            MMWriteAddress - write half-word index (bit 0 picks the half)
//            MMMetric       - N_ACS new metrics, lane i at [W*(i+1)-1:W*i]
//            MMPathMetric   - 2*N_ACS old metrics of the selected word
//            InitBusy       - high while the init sweep runs
// Revision : 1.0 - initial release
// ============================================================================
module metric_memory #(
    parameter int WD_FSM  = metric_memory_pkg::WD_FSM,
    parameter int WD_METR = metric_memory_pkg::WD_METR,
    parameter int N_ACS   = metric_memory_pkg::N_ACS,
    parameter logic [WD_METR-1:0] INIT_HIGH = metric_memory_pkg::INIT_HIGH
) (
    input  logic                        Clock2,
    input  logic                        Reset,
    input  logic                        Active,
    input  logic                        Init,
    input  logic                        MMBlockSelect,
    input  logic [WD_FSM-2:0]           MMReadAddress,
    input  logic [WD_FSM-1:0]           MMWriteAddress,
    input  logic [WD_METR*N_ACS-1:0]    MMMetric,
    output logic [WD_METR*2*N_ACS-1:0]  MMPathMetric,
    output logic                        InitBusy
);
    import metric_memory_pkg::*;

    localparam int ADDR_W = WD_FSM - 1;
    localparam int HALF_W = WD_METR * N_ACS;
    localparam int WORD_W = 2 * HALF_W;

    init_state_t       state;
    init_state_t       state_next;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_next;

    logic              sweep_we;
    logic              acs_we;
    logic [WORD_W-1:0] sweep_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              acs_lo;
    logic              acs_hi;
    logic [WORD_W-1:0] rd_word [2];

    // ---------------- init sweep controller ----------------
    always_ff @(posedge Clock2 or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Init has priority over everything, including a sweep in progress,
    // so a second pulse simply restarts from word 0.
    always_comb begin
        state_next = state;
        count_next = count;
        if (Init) begin
            state_next = SWEEP;
            count_next = '0;
        end else if (state == SWEEP) begin
            count_next = count + 1'b1;
            if (count == '1) begin
                state_next = IDLE;
            end
        end
    end

    assign InitBusy = (state == SWEEP);

    // ---------------- write path ----------------
    assign sweep_we = (state == SWEEP);
    // ACS results arriving while Init or a sweep is active are dropped.
    assign acs_we   = Active && !Init && (state == IDLE);
    assign acs_lo   = acs_we && !MMWriteAddress[0];
    assign acs_hi   = acs_we &&  MMWriteAddress[0];

    // State 0 starts at zero, every other state at INIT_HIGH.
    always_comb begin
        sweep_data = {(2*N_ACS){INIT_HIGH}};
        if (count == '0) begin
            sweep_data[WD_METR-1:0] = '0;
        end
    end

    // The ACS half-word is replicated into both halves; the half enables
    // decide which copy lands.
    assign wr_addr = sweep_we ? count      : MMWriteAddress[WD_FSM-1:1];
    assign wr_data = sweep_we ? sweep_data : {MMMetric, MMMetric};

    // ---------------- banks ----------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic bank_wr_lo;
        logic bank_wr_hi;
        logic is_write_bank;

        // ACS writes only target the bank not selected for reads.
        assign is_write_bank = (MMBlockSelect != 1'(b));
        assign bank_wr_lo    = sweep_we || (acs_lo && is_write_bank);
        assign bank_wr_hi    = sweep_we || (acs_hi && is_write_bank);

        metric_bank #(
            .ADDR_W (ADDR_W),
            .HALF_W (HALF_W)
        ) u_bank (
            .Clock2  (Clock2),
            .rd_addr (MMReadAddress),
            .rd_data (rd_word[b]),
            .wr_lo   (bank_wr_lo),
            .wr_hi   (bank_wr_hi),
            .wr_addr (wr_addr),
            .wr_data (wr_data)
        );
    end

    // Bank select is deliberately unregistered: a toggle shows up at once.
    assign MMPathMetric = MMBlockSelect ? rd_word[1] : rd_word[0];

endmodule
`default_nettype wire

// File: tb/tb_metric_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_metric_memory
// Purpose  : Self-checking bench for metric_memory. A state-indexed reference
//            model predicts every read and the InitBusy flag; expectations
//            are queued and a separate monitor compares them at negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_metric_memory;

    localparam int WD_FSM  = 6;
    localparam int WD_METR = 8;
    localparam int N_ACS   = 4;
    localparam int LANES   = 2 * N_ACS;
    localparam int WORDS   = 32;
    localparam int NSTATES = 256;
    localparam logic [7:0] INIT_HIGH = 8'h40;

    logic        Clock2 = 1'b0;
    logic        Reset  = 1'b0;
    logic        Active = 1'b0;
    logic        Init   = 1'b0;
    logic        MMBlockSelect = 1'b0;
    logic [4:0]  MMReadAddress = '0;
    logic [5:0]  MMWriteAddress = '0;
    logic [31:0] MMMetric = '0;
    logic [63:0] MMPathMetric;
    logic        InitBusy;

    metric_memory #(
        .WD_FSM    (WD_FSM),
        .WD_METR   (WD_METR),
        .N_ACS     (N_ACS),
        .INIT_HIGH (INIT_HIGH)
    ) dut (
        .Clock2         (Clock2),
        .Reset          (Reset),
        .Active         (Active),
        .Init           (Init),
        .MMBlockSelect  (MMBlockSelect),
        .MMReadAddress  (MMReadAddress),
        .MMWriteAddress (MMWriteAddress),
        .MMMetric       (MMMetric),
        .MMPathMetric   (MMPathMetric),
        .InitBusy       (InitBusy)
    );

    always #5 Clock2 = ~Clock2;

    // Reference model: metric of state k in bank b, plus sweep cycles left.
    logic [7:0] mdl [2][NSTATES];
    int         sweep_left = 0;
    bit         model_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk      = 1'b0;

    logic [63:0] q_data[$];
    bit          q_busy[$];
    bit          q_usedata[$];
    string       q_tag[$];

    // Apply the effect of the coming rising edge to the model, then clock.
    task automatic step();
        int wi;
        int wb;
        if (Reset) begin
            if (sweep_left > 0) begin
                wi = WORDS - sweep_left;
                for (int b = 0; b < 2; b++)
                    for (int j = 0; j < LANES; j++)
                        mdl[b][wi*LANES + j] = (wi == 0 && j == 0) ? 8'h00 : INIT_HIGH;
            end else if (Active && !Init) begin
                wb = MMBlockSelect ? 0 : 1;
                for (int i = 0; i < N_ACS; i++)
                    mdl[wb][N_ACS*int'(MMWriteAddress) + i] = MMMetric[i*8 +: 8];
            end
            if (Init) sweep_left = WORDS;
            else if (sweep_left > 0) sweep_left--;
        end
        @(posedge Clock2);
        #1;
    endtask

    // Queue the expected outputs for the current inputs; the monitor checks
    // them at the next falling edge.
    task automatic expect_out(input string tag);
        logic [63:0] e;
        int b;
        b = MMBlockSelect ? 1 : 0;
        for (int j = 0; j < LANES; j++)
            e[j*8 +: 8] = mdl[b][int'(MMReadAddress)*LANES + j];
        q_data.push_back(e);
        q_busy.push_back(sweep_left > 0);
        q_usedata.push_back(model_valid);
        q_tag.push_back(tag);
        chk = 1'b1;
        @(negedge Clock2);
        #1;
        chk = 1'b0;
    endtask

    task automatic check_all_words(input string tag);
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < WORDS; w++) begin
                MMBlockSelect = b[0];
                MMReadAddress = w[4:0];
                expect_out(tag);
            end
        end
    endtask

    task automatic random_acs(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            Active         = ($urandom_range(0, 3) != 0);
            MMBlockSelect  = $urandom_range(0, 1) == 1;
            MMWriteAddress = 6'($urandom_range(0, 63));
            MMMetric       = $urandom;
            MMReadAddress  = 5'($urandom_range(0, 31));
            expect_out(tag);
            step();
        end
        Active = 1'b0;
    endtask

    // Monitor: pops one expectation per flagged cycle.
    always @(negedge Clock2) begin
        logic [63:0] ed;
        bit          eb;
        bit          ud;
        string       tg;
        if (chk) begin
            n_checks++;
            if (q_tag.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                ed = q_data.pop_front();
                eb = q_busy.pop_front();
                ud = q_usedata.pop_front();
                tg = q_tag.pop_front();
                if (InitBusy !== eb || (ud && MMPathMetric !== ed)) begin
                    n_fail++;
                    $display("FAIL %s at %0t: InitBusy=%0b data=%h, expected InitBusy=%0b data=%h",
                             tg, $time, InitBusy, MMPathMetric, eb, ud ? ed : MMPathMetric);
                end
            end
        end
    end

    initial begin
        // Reset state
        step();
        step();
        expect_out("reset_state");
        Reset = 1'b1;
        step();

        // First sweep: InitBusy exactly 32 cycles
        Init = 1'b1;
        step();
        Init = 1'b0;
        for (int c = 0; c < WORDS + 3; c++) begin
            expect_out("init_busy_window");
            step();
        end
        model_valid = 1'b1;
        check_all_words("init_contents");

        // Directed ACS write into bank 1, word 1 high half
        MMBlockSelect  = 1'b0;
        Active         = 1'b1;
        MMWriteAddress = 6'd3;
        MMMetric       = 32'h04030201;
        step();
        Active         = 1'b0;
        MMBlockSelect  = 1'b1;
        MMReadAddress  = 5'd1;
        expect_out("acs_write_bank1_word1");
        if (mdl[1][12] !== 8'h01 || mdl[1][15] !== 8'h04 || mdl[1][8] !== INIT_HIGH) begin
            n_checks++;
            n_fail++;
            $display("FAIL model_directed_write: model word1 lanes not 01..04 over 40s");
        end
        MMBlockSelect  = 1'b0;
        expect_out("acs_bank0_unchanged");

        random_acs(300, "random_acs");

        // ACS writes attempted with Init and throughout the sweep
        Active   = 1'b1;
        Init     = 1'b1;
        MMMetric = $urandom;
        step();
        Init = 1'b0;
        for (int c = 0; c < WORDS; c++) begin
            MMBlockSelect  = $urandom_range(0, 1) == 1;
            MMWriteAddress = 6'($urandom_range(0, 63));
            MMMetric       = $urandom;
            MMReadAddress  = 5'($urandom_range(0, 31));
            expect_out("sweep_blocks_acs");
            step();
        end
        Active = 1'b0;
        check_all_words("sweep_blocks_acs_contents");

        // Init re-pulse at sweep cycle 10
        random_acs(100, "random_fill");
        Init = 1'b1;
        step();
        for (int c = 0; c < 46; c++) begin
            Init          = (c == 10);
            MMBlockSelect = $urandom_range(0, 1) == 1;
            MMReadAddress = 5'($urandom_range(0, 31));
            expect_out("init_restart_window");
            step();
        end
        Init = 1'b0;
        check_all_words("init_restart_contents");

        // Reset at sweep cycle 5
        random_acs(120, "random_fill2");
        Init = 1'b1;
        step();
        Init = 1'b0;
        for (int c = 0; c < 5; c++) begin
            expect_out("pre_reset_sweep");
            step();
        end
        Reset      = 1'b0;
        sweep_left = 0;
        expect_out("reset_busy_immediate");
        step();
        Reset = 1'b1;
        step();
        expect_out("after_reset_idle");
        check_all_words("partial_init_contents");

        if (q_tag.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d expectations never checked", q_tag.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
